// File: rtl/fetch_pc_ctrl.sv
// fetch_pc_ctrl
// Fetch-stage PC controller for the Y86 pipeline.
//
// Chooses the PC to fetch (f_pc) from one of three sources, highest
// priority first:
//   1. the W-stage ret correction
//   2. the M-stage jXX not-taken correction
//   3. the registered prediction F_predPC
// The next prediction comes from the fetched instruction: the jump or call
// target, the return-address stack (RAS) top for a ret, or the
// fall-through PC for everything else.
//
// Optional build macro: FETCH_PERF_CNT_EN
//   Defined   - misprediction counters are built.
//   Undefined - perf_jmp_miss and perf_ret_miss are tied to 0 and no
//               counter flops exist.
//
// Ports
//   clk, rst        clock and synchronous active-high reset
//   F_stall         hold F_predPC and the RAS for this cycle
//   f_icode/f_valC/f_valP
//                   fields of the instruction fetched at f_pc
//   M_icode/M_Cnd/M_valA
//                   M-stage jXX resolution
//   W_icode/W_valM/W_ret_pred_vld/W_ret_predPC
//                   W-stage ret resolution against the prediction
//                   carried down the pipe
//   f_pc            PC to fetch this cycle
//   F_predPC        registered predicted PC
//   f_ret_pred_vld  fetched ret has a valid RAS prediction
//   f_ret_predPC    RAS top (0 when the RAS is empty)
//   f_redirect      f_pc came from an M or W correction
//   perf_jmp_miss   jXX mispredict count
//   perf_ret_miss   ret mispredict count
module fetch_pc_ctrl #(
    parameter int unsigned       ADDR_W    = 64,
    parameter int unsigned       RAS_DEPTH = 8,
    parameter logic [ADDR_W-1:0] RESET_PC  = '0,
    parameter int unsigned       CNT_W     = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              F_stall,
    input  logic [3:0]        f_icode,
    input  logic [ADDR_W-1:0] f_valC,
    input  logic [ADDR_W-1:0] f_valP,
    input  logic [3:0]        M_icode,
    input  logic              M_Cnd,
    input  logic [ADDR_W-1:0] M_valA,
    input  logic [3:0]        W_icode,
    input  logic [ADDR_W-1:0] W_valM,
    input  logic              W_ret_pred_vld,
    input  logic [ADDR_W-1:0] W_ret_predPC,
    output logic [ADDR_W-1:0] f_pc,
    output logic [ADDR_W-1:0] F_predPC,
    output logic              f_ret_pred_vld,
    output logic [ADDR_W-1:0] f_ret_predPC,
    output logic              f_redirect,
    output logic [CNT_W-1:0]  perf_jmp_miss,
    output logic [CNT_W-1:0]  perf_ret_miss
);

    localparam int unsigned      PTR_W    = (RAS_DEPTH > 1) ? $clog2(RAS_DEPTH) : 1;
    localparam int unsigned      OCC_W    = $clog2(RAS_DEPTH + 1);
    localparam logic [OCC_W-1:0] OCC_FULL = OCC_W'(RAS_DEPTH);
    localparam logic [3:0]       I_JXX    = 4'h7;
    localparam logic [3:0]       I_CALL   = 4'h8;
    localparam logic [3:0]       I_RET    = 4'h9;

    logic [ADDR_W-1:0] pred_pc_q, pred_pc_d;
    logic [ADDR_W-1:0] ras_q [RAS_DEPTH];
    logic [ADDR_W-1:0] ras_d [RAS_DEPTH];
    logic [PTR_W-1:0]  ptr_q, ptr_d;
    logic [OCC_W-1:0]  occ_q, occ_d;

    logic              w_miss;
    logic              m_miss;
    logic              ras_nonempty;
    logic [ADDR_W-1:0] ras_top;
    logic [ADDR_W-1:0] f_pred_pc;

    // Correction detection and PC select. The W ret is older than the jXX
    // in M, so a W correction makes the M jXX wrong-path and wins.
    always_comb begin
        w_miss = (W_icode == I_RET) && (!W_ret_pred_vld || (W_valM != W_ret_predPC));
        m_miss = (M_icode == I_JXX) && !M_Cnd;
        f_redirect = w_miss || m_miss;
        if (w_miss) begin
            f_pc = W_valM;
        end else if (m_miss) begin
            f_pc = M_valA;
        end else begin
            f_pc = pred_pc_q;
        end
    end

    // ptr_q points at the next free slot, so the top sits one below it.
    // Once full, the next push lands on the oldest entry; that is the
    // intended circular overwrite.
    always_comb begin
        ras_nonempty   = (occ_q != '0);
        ras_top        = ras_q[ptr_q - PTR_W'(1)];
        f_ret_predPC   = ras_nonempty ? ras_top : '0;
        f_ret_pred_vld = (f_icode == I_RET) && ras_nonempty;

        if ((f_icode == I_JXX) || (f_icode == I_CALL)) begin
            f_pred_pc = f_valC;
        end else if (f_ret_pred_vld) begin
            f_pred_pc = ras_top;
        end else begin
            f_pred_pc = f_valP;
        end
    end

    // Prediction register and RAS next state. Wrong-path pushes and pops
    // are not undone on redirect; the W-stage check catches any ret that
    // a corrupted stack mispredicts.
    always_comb begin
        pred_pc_d = pred_pc_q;
        ras_d     = ras_q;
        ptr_d     = ptr_q;
        occ_d     = occ_q;
        if (!F_stall) begin
            pred_pc_d = f_pred_pc;
            if (f_icode == I_CALL) begin
                ras_d[ptr_q] = f_valP;
                ptr_d        = ptr_q + PTR_W'(1);
                if (occ_q != OCC_FULL) begin
                    occ_d = occ_q + OCC_W'(1);
                end
            end else if (f_ret_pred_vld) begin
                ptr_d = ptr_q - PTR_W'(1);
                occ_d = occ_q - OCC_W'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            pred_pc_q <= RESET_PC;
            ras_q     <= '{default: '0};
            ptr_q     <= '0;
            occ_q     <= '0;
        end else begin
            pred_pc_q <= pred_pc_d;
            ras_q     <= ras_d;
            ptr_q     <= ptr_d;
            occ_q     <= occ_d;
        end
    end

    assign F_predPC = pred_pc_q;

`ifdef FETCH_PERF_CNT_EN
    logic [CNT_W-1:0] jmp_miss_q, jmp_miss_d;
    logic [CNT_W-1:0] ret_miss_q, ret_miss_d;

    // A jXX miss shadowed by a W ret miss is wrong-path and is not counted.
    always_comb begin
        jmp_miss_d = jmp_miss_q;
        ret_miss_d = ret_miss_q;
        if (m_miss && !w_miss) begin
            jmp_miss_d = jmp_miss_q + CNT_W'(1);
        end
        if (w_miss) begin
            ret_miss_d = ret_miss_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            jmp_miss_q <= '0;
            ret_miss_q <= '0;
        end else begin
            jmp_miss_q <= jmp_miss_d;
            ret_miss_q <= ret_miss_d;
        end
    end

    assign perf_jmp_miss = jmp_miss_q;
    assign perf_ret_miss = ret_miss_q;
`else
    assign perf_jmp_miss = '0;
    assign perf_ret_miss = '0;
`endif

endmodule

// File: tb/tb_fetch_pc_ctrl.sv
// tb_fetch_pc_ctrl
// Scoreboard bench for fetch_pc_ctrl. The driver applies one stimulus per
// cycle just after the rising edge. It computes the expected outputs from
// a behavioural model (the RAS is a bounded queue, the prediction is a
// plain variable) and pushes them to a queue. A monitor pops and compares
// on every falling edge.
module tb_fetch_pc_ctrl;

    localparam int unsigned      AW     = 64;
    localparam int unsigned      DEPTH  = 8;
    localparam int unsigned      CW     = 32;
    localparam logic [AW-1:0]    RST_PC = '0;

    typedef struct {
        logic          rst;
        logic          stall;
        logic [3:0]    f_icode;
        logic [AW-1:0] f_valC;
        logic [AW-1:0] f_valP;
        logic [3:0]    m_icode;
        logic          m_cnd;
        logic [AW-1:0] m_valA;
        logic [3:0]    w_icode;
        logic [AW-1:0] w_valM;
        logic          w_vld;
        logic [AW-1:0] w_predPC;
    } stim_t;

    typedef struct {
        logic [AW-1:0] f_pc;
        logic [AW-1:0] pred_pc;
        logic          ret_vld;
        logic [AW-1:0] ret_pc;
        logic          redirect;
        logic [CW-1:0] jmp_cnt;
        logic [CW-1:0] ret_cnt;
    } exp_t;

    logic          clk = 1'b0;
    logic          rst;
    logic          F_stall;
    logic [3:0]    f_icode;
    logic [AW-1:0] f_valC;
    logic [AW-1:0] f_valP;
    logic [3:0]    M_icode;
    logic          M_Cnd;
    logic [AW-1:0] M_valA;
    logic [3:0]    W_icode;
    logic [AW-1:0] W_valM;
    logic          W_ret_pred_vld;
    logic [AW-1:0] W_ret_predPC;
    logic [AW-1:0] f_pc;
    logic [AW-1:0] F_predPC;
    logic          f_ret_pred_vld;
    logic [AW-1:0] f_ret_predPC;
    logic          f_redirect;
    logic [CW-1:0] perf_jmp_miss;
    logic [CW-1:0] perf_ret_miss;

    exp_t          exp_q[$];
    logic [AW-1:0] ras_m[$];
    logic [AW-1:0] pred_m;
    logic [CW-1:0] jmp_m;
    logic [CW-1:0] ret_m;
    bit            known = 1'b0;
    int            checks = 0;
    int            errors = 0;

    fetch_pc_ctrl #(
        .ADDR_W   (AW),
        .RAS_DEPTH(DEPTH),
        .RESET_PC (RST_PC),
        .CNT_W    (CW)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .F_stall       (F_stall),
        .f_icode       (f_icode),
        .f_valC        (f_valC),
        .f_valP        (f_valP),
        .M_icode       (M_icode),
        .M_Cnd         (M_Cnd),
        .M_valA        (M_valA),
        .W_icode       (W_icode),
        .W_valM        (W_valM),
        .W_ret_pred_vld(W_ret_pred_vld),
        .W_ret_predPC  (W_ret_predPC),
        .f_pc          (f_pc),
        .F_predPC      (F_predPC),
        .f_ret_pred_vld(f_ret_pred_vld),
        .f_ret_predPC  (f_ret_predPC),
        .f_redirect    (f_redirect),
        .perf_jmp_miss (perf_jmp_miss),
        .perf_ret_miss (perf_ret_miss)
    );

    always #5 clk = ~clk;

    // Quiet cycle: a plain fetch with no pending corrections.
    function automatic stim_t nop(input logic [AW-1:0] valP);
        stim_t s;
        s.rst      = 1'b0;
        s.stall    = 1'b0;
        s.f_icode  = 4'h1;
        s.f_valC   = '0;
        s.f_valP   = valP;
        s.m_icode  = 4'h0;
        s.m_cnd    = 1'b0;
        s.m_valA   = '0;
        s.w_icode  = 4'h0;
        s.w_valM   = '0;
        s.w_vld    = 1'b0;
        s.w_predPC = '0;
        return s;
    endfunction

    function automatic logic [AW-1:0] rand_addr();
        return {$urandom(), $urandom()};
    endfunction

    // Drive one cycle, record the expected outputs, then advance the model
    // to the state it should hold after the coming edge.
    task automatic applyStimulus(input stim_t s);
        exp_t          e;
        logic          wm;
        logic          mm;
        logic [AW-1:0] nxt;
        rst            = s.rst;
        F_stall        = s.stall;
        f_icode        = s.f_icode;
        f_valC         = s.f_valC;
        f_valP         = s.f_valP;
        M_icode        = s.m_icode;
        M_Cnd          = s.m_cnd;
        M_valA         = s.m_valA;
        W_icode        = s.w_icode;
        W_valM         = s.w_valM;
        W_ret_pred_vld = s.w_vld;
        W_ret_predPC   = s.w_predPC;

        wm = (s.w_icode == 4'd9) && (!s.w_vld || (s.w_valM != s.w_predPC));
        mm = (s.m_icode == 4'd7) && !s.m_cnd;
        e.f_pc     = wm ? s.w_valM : (mm ? s.m_valA : pred_m);
        e.pred_pc  = pred_m;
        e.ret_vld  = (s.f_icode == 4'd9) && (ras_m.size() != 0);
        e.ret_pc   = (ras_m.size() != 0) ? ras_m[$] : '0;
        e.redirect = wm || mm;
`ifdef FETCH_PERF_CNT_EN
        e.jmp_cnt  = jmp_m;
        e.ret_cnt  = ret_m;
`else
        e.jmp_cnt  = '0;
        e.ret_cnt  = '0;
`endif
        if (known) exp_q.push_back(e);

        if (s.rst) begin
            pred_m = RST_PC;
            ras_m.delete();
            jmp_m  = '0;
            ret_m  = '0;
            known  = 1'b1;
        end else begin
            if (mm && !wm) jmp_m = jmp_m + 1'b1;
            if (wm) ret_m = ret_m + 1'b1;
            if (!s.stall) begin
                if (s.f_icode == 4'd7 || s.f_icode == 4'd8) nxt = s.f_valC;
                else if (s.f_icode == 4'd9 && ras_m.size() != 0) nxt = ras_m[$];
                else nxt = s.f_valP;
                pred_m = nxt;
                if (s.f_icode == 4'd8) begin
                    ras_m.push_back(s.f_valP);
                    if (ras_m.size() > DEPTH) ras_m.delete(0);
                end else if (s.f_icode == 4'd9 && ras_m.size() != 0) begin
                    void'(ras_m.pop_back());
                end
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic checkOutput(input string name, input logic [AW-1:0] act, input logic [AW-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s actual=%h expected=%h at %0t", name, act, exp, $time);
        end
    endtask

    // Monitor: compare whatever the driver recorded for this cycle.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (exp_q.size() != 0) begin
                e = exp_q.pop_front();
                checkOutput("f_pc", f_pc, e.f_pc);
                checkOutput("F_predPC", F_predPC, e.pred_pc);
                checkOutput("f_ret_pred_vld", AW'(f_ret_pred_vld), AW'(e.ret_vld));
                checkOutput("f_ret_predPC", f_ret_predPC, e.ret_pc);
                checkOutput("f_redirect", AW'(f_redirect), AW'(e.redirect));
                checkOutput("perf_jmp_miss", AW'(perf_jmp_miss), AW'(e.jmp_cnt));
                checkOutput("perf_ret_miss", AW'(perf_ret_miss), AW'(e.ret_cnt));
            end
        end
    end

    // Hard time limit so the bench can never hang.
    initial begin
        #2000000;
        $display("[TB] FAIL timeout actual=running required=finished");
        $fatal(1, "[TB] timeout");
    end

    initial begin
        stim_t s;
        int    r;

        // Reset, then a plain fetch with fall-through 0x0A.
        s = nop(64'h0A); s.rst = 1'b1;
        applyStimulus(s);
        applyStimulus(nop(64'h0A));
        applyStimulus(nop(64'h14));

        // Call then ret: the ret predicts the call's fall-through.
        s = nop(64'h120); s.f_icode = 4'd8; s.f_valC = 64'h400;
        applyStimulus(s);
        s = nop(64'h401); s.f_icode = 4'd9;
        applyStimulus(s);
        applyStimulus(nop(64'h121));

        // M-stage jXX not taken.
        s = nop(64'h30); s.m_icode = 4'd7; s.m_cnd = 1'b0; s.m_valA = 64'h88;
        applyStimulus(s);

        // W ret miss together with an M jXX miss: W wins.
        s = nop(64'h90); s.m_icode = 4'd7; s.m_valA = 64'h88;
        s.w_icode = 4'd9; s.w_vld = 1'b1; s.w_predPC = 64'h120; s.w_valM = 64'h200;
        applyStimulus(s);

        // W ret with a correct prediction: no redirect.
        s = nop(64'h204); s.w_icode = 4'd9; s.w_vld = 1'b1;
        s.w_predPC = 64'h208; s.w_valM = 64'h208;
        applyStimulus(s);

        // Overfill the RAS, then drain it one past empty.
        s = nop(64'h0); s.rst = 1'b1;
        applyStimulus(s);
        for (int i = 0; i <= DEPTH; i++) begin
            s = nop(AW'((i + 1) * 16)); s.f_icode = 4'd8; s.f_valC = AW'(64'h1000 + i);
            applyStimulus(s);
        end
        for (int i = 0; i <= DEPTH; i++) begin
            s = nop(AW'(64'h2000 + i)); s.f_icode = 4'd9;
            applyStimulus(s);
        end
        applyStimulus(nop(64'h3000));

        // Stalled call holds everything, released call pushes.
        s = nop(64'h500); s.f_icode = 4'd8; s.f_valC = 64'h700; s.stall = 1'b1;
        applyStimulus(s);
        applyStimulus(s);
        s.stall = 1'b0;
        applyStimulus(s);
        s = nop(64'h704); s.f_icode = 4'd9;
        applyStimulus(s);

        // Randomised traffic with occasional stalls and resets.
        for (int n = 0; n < 3000; n++) begin
            s = nop(rand_addr());
            s.f_valC = rand_addr();
            r = $urandom_range(0, 9);
            if (r < 3) s.f_icode = 4'd8;
            else if (r < 6) s.f_icode = 4'd9;
            else if (r < 7) s.f_icode = 4'd7;
            else s.f_icode = 4'($urandom_range(0, 11));
            s.stall   = ($urandom_range(0, 4) == 0);
            s.rst     = ($urandom_range(0, 199) == 0);
            s.m_icode = ($urandom_range(0, 3) == 0) ? 4'd7 : 4'($urandom_range(0, 11));
            s.m_cnd   = 1'($urandom_range(0, 1));
            s.m_valA  = rand_addr();
            s.w_icode = ($urandom_range(0, 3) == 0) ? 4'd9 : 4'($urandom_range(0, 11));
            s.w_vld   = ($urandom_range(0, 3) != 0);
            s.w_predPC = rand_addr();
            s.w_valM  = ($urandom_range(0, 1) == 0) ? s.w_predPC : rand_addr();
            applyStimulus(s);
        end

        repeat (2) @(negedge clk);
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("[TB] FAIL scoreboard_drain actual=%0d required=0", exp_q.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
